// File: rtl/lagarto_plic_pkg.sv
// Shared types and constants for the PLIC per-context claim controller.
// Contents:
//   source_state_t   - per-source lifecycle state (idle / pending / in service)
//   NO_INTERRUPT_ID  - ID returned when no source is eligible
//   DEFAULT_*        - default source count and priority width
//   id_width()       - bits needed to encode IDs 0..num_sources
package lagarto_plic_pkg;

    localparam int unsigned DEFAULT_NUM_SOURCES    = 8;
    localparam int unsigned DEFAULT_PRIORITY_WIDTH = 3;
    localparam int unsigned NO_INTERRUPT_ID        = 0;

    typedef enum logic [1:0] {
        SRC_IDLE       = 2'b00,
        SRC_PENDING    = 2'b01,
        SRC_IN_SERVICE = 2'b10
    } source_state_t;

    // ID 0 is reserved for "no interrupt", so NUM_SOURCES+1 codes are needed.
    function automatic int unsigned id_width(input int unsigned num_sources);
        return $clog2(num_sources + 1);
    endfunction

endpackage

// File: rtl/lagarto_plic_priority_tree.sv
// Combinational selector: highest priority among eligible sources, ties to
// the lowest ID; returns NO_INTERRUPT_ID when nothing is eligible.
// Ports:
//   eligible_i  - per-source eligibility; bit i-1 is source i
//   priority_i  - packed per-source priorities; slice i-1 is source i
//   id_o        - winning source ID (0 = none)
module lagarto_plic_priority_tree
    import lagarto_plic_pkg::*;
#(
    parameter int unsigned NUM_SOURCES    = DEFAULT_NUM_SOURCES,
    parameter int unsigned PRIORITY_WIDTH = DEFAULT_PRIORITY_WIDTH,
    parameter int unsigned ID_WIDTH       = id_width(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0]                eligible_i,
    input  logic [NUM_SOURCES*PRIORITY_WIDTH-1:0] priority_i,
    output logic [ID_WIDTH-1:0]                   id_o
);

    logic [PRIORITY_WIDTH-1:0] best_prio;
    logic [ID_WIDTH-1:0]       best_id;

    // Ascending scan with a strict compare keeps the lowest ID on ties.
    // Eligible sources always have priority > threshold >= 0, so starting
    // from zero never lets a priority-0 source win.
    always_comb begin
        best_prio = '0;
        best_id   = ID_WIDTH'(NO_INTERRUPT_ID);
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            if (eligible_i[i] &&
                (priority_i[i*PRIORITY_WIDTH +: PRIORITY_WIDTH] > best_prio)) begin
                best_prio = priority_i[i*PRIORITY_WIDTH +: PRIORITY_WIDTH];
                best_id   = ID_WIDTH'(i + 1);
            end
        end
    end

    assign id_o = best_id;

endmodule

// File: rtl/lagarto_plic_claim_controller.sv
// Per-context PLIC target: tracks pending/in-service state per source,
// arbitrates against the context threshold, drives the hart interrupt line,
// sequences claim/complete and keeps each gateway closed while in service.
// Ports:
//   clk_i, rst_i            - clock, async active-high reset
//   interrupt_request_i     - per-source gateway requests (bit i-1 = source i)
//   source_priority_i       - packed per-source priorities
//   enable_i, threshold_i   - context enables and priority threshold
//   claim_i                 - claim-register read strobe
//   complete_i/complete_id_i- complete-register write strobe and ID
//   claim_id_o/claim_valid_o- claimed ID and its one-cycle valid pulse
//   external_interrupt_o    - registered "something eligible" to the hart
//   interrupt_complete_o    - per-source gateway open (0 while in service)
//   pending_o               - pending bits for register readback
module lagarto_plic_claim_controller
    import lagarto_plic_pkg::*;
#(
    parameter int unsigned NUM_SOURCES    = DEFAULT_NUM_SOURCES,
    parameter int unsigned PRIORITY_WIDTH = DEFAULT_PRIORITY_WIDTH,
    parameter int unsigned ID_WIDTH       = id_width(NUM_SOURCES)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_SOURCES-1:0]                interrupt_request_i,
    input  logic [NUM_SOURCES*PRIORITY_WIDTH-1:0] source_priority_i,
    input  logic [NUM_SOURCES-1:0]                enable_i,
    input  logic [PRIORITY_WIDTH-1:0]             threshold_i,
    input  logic                                  claim_i,
    input  logic                                  complete_i,
    input  logic [ID_WIDTH-1:0]                   complete_id_i,
    output logic [ID_WIDTH-1:0]                   claim_id_o,
    output logic                                  claim_valid_o,
    output logic                                  external_interrupt_o,
    output logic [NUM_SOURCES-1:0]                interrupt_complete_o,
    output logic [NUM_SOURCES-1:0]                pending_o
);

    source_state_t              state_q [NUM_SOURCES];
    source_state_t              state_d [NUM_SOURCES];
    logic [NUM_SOURCES-1:0]     eligible;
    logic [ID_WIDTH-1:0]        arb_id;
    logic [ID_WIDTH-1:0]        claim_id_q;
    logic                       claim_valid_q;
    logic                       ext_irq_q;
    logic [NUM_SOURCES-1:0]     int_complete_q;

    always_comb begin
        eligible  = '0;
        pending_o = '0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            pending_o[i] = (state_q[i] == SRC_PENDING);
            eligible[i]  = (state_q[i] == SRC_PENDING) && enable_i[i] &&
                           (source_priority_i[i*PRIORITY_WIDTH +: PRIORITY_WIDTH] > threshold_i);
        end
    end

    lagarto_plic_priority_tree #(
        .NUM_SOURCES    (NUM_SOURCES),
        .PRIORITY_WIDTH (PRIORITY_WIDTH),
        .ID_WIDTH       (ID_WIDTH)
    ) u_priority_tree (
        .eligible_i (eligible),
        .priority_i (source_priority_i),
        .id_o       (arb_id)
    );

    // Claim and complete act on disjoint states (PENDING vs IN_SERVICE), so
    // a same-cycle claim/complete never contends for one source. IDs 0 and
    // out-of-range completes simply match no source.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                SRC_IDLE: begin
                    if (interrupt_request_i[i]) state_d[i] = SRC_PENDING;
                end
                SRC_PENDING: begin
                    if (claim_i && (arb_id == ID_WIDTH'(i + 1))) state_d[i] = SRC_IN_SERVICE;
                end
                SRC_IN_SERVICE: begin
                    if (complete_i && (complete_id_i == ID_WIDTH'(i + 1))) state_d[i] = SRC_IDLE;
                end
                default: state_d[i] = SRC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
                state_q[i] <= SRC_IDLE;
            end
            claim_id_q     <= '0;
            claim_valid_q  <= 1'b0;
            ext_irq_q      <= 1'b0;
            int_complete_q <= '1;
        end else begin
            for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
                state_q[i]        <= state_d[i];
                // Follows the registered state, so the gateway sees the
                // change one cycle after the FSM transition.
                int_complete_q[i] <= (state_q[i] != SRC_IN_SERVICE);
            end
            if (claim_i) begin
                claim_id_q <= arb_id;
            end
            claim_valid_q <= claim_i;
            ext_irq_q     <= (arb_id != ID_WIDTH'(NO_INTERRUPT_ID));
        end
    end

    assign claim_id_o           = claim_id_q;
    assign claim_valid_o        = claim_valid_q;
    assign external_interrupt_o = ext_irq_q;
    assign interrupt_complete_o = int_complete_q;

endmodule

// File: tb/tb_lagarto_plic_claim_controller.sv
module tb_lagarto_plic_claim_controller;

    localparam int unsigned NS = 8;
    localparam int unsigned PW = 3;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] req;
    logic [PW-1:0] prio [1:NS];
    logic [NS*PW-1:0] prio_vec;
    logic [NS-1:0] en;
    logic [PW-1:0] thr;
    logic          claim;
    logic          complete;
    logic [IW-1:0] complete_id;
    logic [IW-1:0] claim_id;
    logic          claim_valid;
    logic          ext_irq;
    logic [NS-1:0] int_complete;
    logic [NS-1:0] pending;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [IW-1:0] exp_q [$];

    always #5 clk = ~clk;

    always_comb begin
        prio_vec = '0;
        for (int i = 1; i <= int'(NS); i++) prio_vec[(i-1)*PW +: PW] = prio[i];
    end

    lagarto_plic_claim_controller #(
        .NUM_SOURCES    (NS),
        .PRIORITY_WIDTH (PW),
        .ID_WIDTH       (IW)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .interrupt_request_i  (req),
        .source_priority_i    (prio_vec),
        .enable_i             (en),
        .threshold_i          (thr),
        .claim_i              (claim),
        .complete_i           (complete),
        .complete_id_i        (complete_id),
        .claim_id_o           (claim_id),
        .claim_valid_o        (claim_valid),
        .external_interrupt_o (ext_irq),
        .interrupt_complete_o (int_complete),
        .pending_o            (pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic verify_claim(input string tag);
        logic [IW-1:0] e;
        check({tag, "_valid"}, 32'(claim_valid), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hF;
        check({tag, "_id"}, 32'(claim_id), 32'(e));
    endtask

    task automatic do_claim(input string tag, input logic [IW-1:0] exp_id);
        claim = 1'b1;
        exp_q.push_back(exp_id);
        tick();
        claim = 1'b0;
        verify_claim(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; en = '1; thr = '0;
        claim = 1'b0; complete = 1'b0; complete_id = '0;
        for (int i = 1; i <= int'(NS); i++) prio[i] = '0;
        tick(); tick();
        check("rst_claim_id", 32'(claim_id), 32'd0);
        check("rst_valid", 32'(claim_valid), 32'd0);
        check("rst_ext", 32'(ext_irq), 32'd0);
        check("rst_ic", 32'(int_complete), 32'hFF);
        check("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;

        // 1: single source 3, priority 2
        prio[3] = 3'd2; req[2] = 1'b1;
        tick();
        check("t1_pending", 32'(pending), 32'h04);
        check("t1_ext_lat", 32'(ext_irq), 32'd0);
        tick();
        check("t1_ext", 32'(ext_irq), 32'd1);
        do_claim("t1_claim", 4'd3);
        check("t1_pend_clr", 32'(pending), 32'h00);
        check("t1_ic_lat", 32'(int_complete[2]), 32'd1);
        tick();
        check("t1_ic", 32'(int_complete[2]), 32'd0);
        check("t1_ext_off", 32'(ext_irq), 32'd0);
        check("t1_valid_pulse", 32'(claim_valid), 32'd0);

        // 2: tie between sources 2 and 5 at priority 4
        prio[2] = 3'd4; prio[5] = 3'd4; req[1] = 1'b1; req[4] = 1'b1;
        tick();
        req[1] = 1'b0; req[4] = 1'b0;
        check("t2_pending", 32'(pending), 32'h12);
        tick();
        do_claim("t2_claim_a", 4'd2);
        do_claim("t2_claim_b", 4'd5);
        do_claim("t2_claim_none", 4'd0);
        check("t2_pend_none", 32'(pending), 32'h00);
        tick();
        check("t2_ic", 32'(int_complete), 32'hE9);

        // 3: threshold boundary and priority 0
        prio[4] = 3'd3; thr = 3'd3; req[3] = 1'b1;
        tick();
        req[3] = 1'b0;
        check("t3_pending", 32'(pending), 32'h08);
        tick();
        check("t3_ext_eq_thr", 32'(ext_irq), 32'd0);
        thr = 3'd2;
        tick();
        check("t3_ext_thr_lowered", 32'(ext_irq), 32'd1);
        do_claim("t3_claim", 4'd4);
        req[7] = 1'b1;
        tick();
        req[7] = 1'b0;
        check("t3_p0_pending", 32'(pending), 32'h80);
        tick();
        check("t3_p0_ext", 32'(ext_irq), 32'd0);
        thr = 3'd0;
        tick(); tick();
        check("t3_p0_ext_thr0", 32'(ext_irq), 32'd0);
        do_claim("t3_p0_claim", 4'd0);

        // 4: ignored completes, then real complete with held request
        complete = 1'b1;
        complete_id = 4'd0; tick();
        complete_id = 4'd9; tick();
        complete_id = 4'd1; tick();
        complete = 1'b0;
        tick();
        check("t4_ic_ignored", 32'(int_complete), 32'hE1);
        check("t4_pend_ignored", 32'(pending), 32'h80);
        complete = 1'b1; complete_id = 4'd3;
        tick();
        complete = 1'b0;
        check("t4_pend_idle", 32'(pending), 32'h80);
        check("t4_ic_lat", 32'(int_complete[2]), 32'd0);
        tick();
        check("t4_ic_open", 32'(int_complete[2]), 32'd1);
        check("t4_repend", 32'(pending), 32'h84);
        tick();
        check("t4_ext", 32'(ext_irq), 32'd1);

        // 5: same-cycle claim of 6 and complete of 3
        do_claim("t5_claim3", 4'd3);
        req[2] = 1'b0;
        prio[6] = 3'd5; req[5] = 1'b1;
        tick();
        req[5] = 1'b0;
        check("t5_pending6", 32'(pending), 32'hA0);
        claim = 1'b1; complete = 1'b1; complete_id = 4'd3;
        exp_q.push_back(4'd6);
        tick();
        claim = 1'b0; complete = 1'b0;
        verify_claim("t5_claim6");
        check("t5_pending", 32'(pending), 32'h80);
        tick();
        check("t5_ic", 32'(int_complete), 32'hC5);

        // 6: async reset with sources 1 and 7 in service
        prio[1] = 3'd6; prio[7] = 3'd7; req[0] = 1'b1; req[6] = 1'b1;
        tick();
        req[0] = 1'b0; req[6] = 1'b0;
        do_claim("t6_claim7", 4'd7);
        do_claim("t6_claim1", 4'd1);
        tick();
        check("t6_ic_pre", 32'(int_complete), 32'h84);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_ic", 32'(int_complete), 32'hFF);
        check("t6_rst_pending", 32'(pending), 32'h00);
        check("t6_rst_ext", 32'(ext_irq), 32'd0);
        check("t6_rst_valid", 32'(claim_valid), 32'd0);
        check("t6_rst_id", 32'(claim_id), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_ic", 32'(int_complete), 32'hFF);
        check("t6_post_pending", 32'(pending), 32'h00);
        check("t6_post_ext", 32'(ext_irq), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
